dmem_responder: RTL and testbench

Data-memory responder for the multicycle MIPS core. It sits on the slave side of the core's load/store port. It accepts one request at a time over a req/ack handshake and stores data little-endian. It performs byte and half-word lane steering with optional sign extension. It flags misaligned or out-of-range accesses. Access latency is configurable through a wait-state count, so the core's MEM state can be exercised against slow memory.

---
 rtl/mem_pkg.sv | 36 +++
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_responder.sv | 150 +++++++++++++++
 tb/tb_dmem_responder.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: access sizes, FSM states,
// the captured request record and the byte-enable helper.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    size_e       size;
    logic        sign_ext;
    logic [31:0] wdata;
  } req_t;

  // Little-endian lane selection: lane 0 is bits [7:0] of the word.
  function automatic logic [3:0] byte_en(size_e size, logic [1:0] off);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << off;
      SZ_HALF: byte_en = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
interface dmem_responder_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, size, sign_ext, wdata,
    input  ack, rdata, err, busy
  );

  modport slave (
    input  req, we, addr, size, sign_ext, wdata,
    output ack, rdata, err, busy
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, 2^DEPTH_LOG2 x 32, per-byte write enables,
// registered read. Read-during-write returns the previous word.
module dmem_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic [3:0]            be_i,
  input  logic [DEPTH_LOG2-1:0] idx_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**DEPTH_LOG2];
  logic [31:0] rdata_q;

  // NOTE: the storage array is deliberately not reset, so it maps onto a RAM
  // macro; contents after power-up are undefined until written.
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the multicycle MIPS core: req/ack slave with
// configurable wait states, little-endian lane steering and error flagging.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input logic             clk,
  input logic             reset_n,
  dmem_responder_if.slave bus
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q;
  req_t        live_req;
  logic        err_q;

  logic        acc_we;
  logic [31:0] acc_addr;
  size_e       acc_size;
  logic [31:0] acc_wdata;
  logic        acc_err;
  logic        enter_resp;

  logic [3:0]  arr_be;
  logic [31:0] arr_wdata;
  logic [31:0] arr_rdata;
  logic [31:0] shifted;
  logic [31:0] load_val;

  assign live_req = '{we:       bus.we,
                      addr:     bus.addr,
                      size:     size_e'(bus.size),
                      sign_ext: bus.sign_ext,
                      wdata:    bus.wdata};

  // In IDLE the live request drives the array so a zero-wait access can
  // commit on its acceptance edge; afterwards only the captured copy is used.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we    = live_req.we;
      acc_addr  = live_req.addr;
      acc_size  = live_req.size;
      acc_wdata = live_req.wdata;
    end else begin
      acc_we    = req_q.we;
      acc_addr  = req_q.addr;
      acc_size  = req_q.size;
      acc_wdata = req_q.wdata;
    end
  end

  assign acc_err = (acc_size == SZ_BAD)
                || (acc_size == SZ_HALF && acc_addr[0])
                || (acc_size == SZ_WORD && acc_addr[1:0] != 2'b00)
                || ((acc_addr >> (DEPTH_LOG2 + 2)) != 32'd0);

  // NOTE: every variable written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_resp = (state_d == RESP);

  // Stores replicate the right-aligned data across the word; the enables pick the lanes.
  always_comb begin
    arr_wdata = acc_wdata;
    case (acc_size)
      SZ_BYTE: arr_wdata = {4{acc_wdata[7:0]}};
      SZ_HALF: arr_wdata = {2{acc_wdata[15:0]}};
      default: arr_wdata = acc_wdata;
    endcase
  end

  // Rejected accesses and a write edge racing reset both leave memory untouched.
  assign arr_be = (enter_resp && acc_we && !acc_err && reset_n)
                ? byte_en(acc_size, acc_addr[1:0]) : 4'b0000;

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .en_i    (enter_resp),
    .be_i    (arr_be),
    .idx_i   (acc_addr[DEPTH_LOG2+1:2]),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && bus.req) begin
        req_q <= live_req;
      end
      err_q <= enter_resp ? acc_err : 1'b0;
    end
  end

  always_comb begin
    shifted  = arr_rdata >> {req_q.addr[1:0], 3'b000};
    load_val = shifted;
    case (req_q.size)
      SZ_BYTE: load_val = {{24{req_q.sign_ext & shifted[7]}},  shifted[7:0]};
      SZ_HALF: load_val = {{16{req_q.sign_ext & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  assign bus.ack   = (state_q == RESP);
  assign bus.busy  = (state_q != IDLE);
  assign bus.err   = err_q;
  assign bus.rdata = (state_q == RESP && !err_q && !req_q.we) ? load_val : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: two responders (1 and 3 wait states) checked every
// cycle against a byte-level memory model with transaction-level timing.
module tb_dmem_responder;
  import mem_pkg::*;

  localparam int DL2 = 10;
  localparam int WC0 = 1;
  localparam int WC1 = 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();

  dmem_responder #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(WC0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0));
  dmem_responder #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(WC1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1));

  logic        req_s [2], we_s [2], sx_s [2];
  logic [31:0] addr_s [2], wd_s [2];
  logic [1:0]  size_s [2];
  logic        ack_s [2], busy_s [2], err_s [2];
  logic [31:0] rdata_s [2];

  assign req_s[0] = bus0.req;   assign req_s[1] = bus1.req;
  assign we_s[0]  = bus0.we;    assign we_s[1]  = bus1.we;
  assign sx_s[0]  = bus0.sign_ext; assign sx_s[1] = bus1.sign_ext;
  assign addr_s[0] = bus0.addr; assign addr_s[1] = bus1.addr;
  assign wd_s[0]  = bus0.wdata; assign wd_s[1]  = bus1.wdata;
  assign size_s[0] = bus0.size; assign size_s[1] = bus1.size;
  assign ack_s[0] = bus0.ack;   assign ack_s[1] = bus1.ack;
  assign busy_s[0] = bus0.busy; assign busy_s[1] = bus1.busy;
  assign err_s[0] = bus0.err;   assign err_s[1] = bus1.err;
  assign rdata_s[0] = bus0.rdata; assign rdata_s[1] = bus1.rdata;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic int wc(input int d);
    return (d == 0) ? WC0 : WC1;
  endfunction

  // ---------------- reference model ----------------
  // since[d]: cycles elapsed since acceptance (-1 = no transaction).
  int          since [2] = '{-1, -1};
  logic [7:0]  mem_m [longint];
  logic        p_we [2], p_sx [2];
  logic [31:0] p_addr [2], p_wd [2];
  logic [1:0]  p_size [2];
  logic        exp_err [2];
  logic [31:0] exp_rd [2];
  logic        exp_known [2];

  task automatic resolve(input int d);
    longint      base;
    longint      key;
    int          n;
    logic        rej;
    logic [31:0] val;
    base = longint'(d) << 32;
    n    = 1 << p_size[d];
    rej  = (p_size[d] == 2'b11) || ((p_addr[d] % n) != 0) || (p_addr[d] >= (1 << (DL2 + 2)));
    exp_err[d]   = rej;
    exp_rd[d]    = 32'd0;
    exp_known[d] = 1'b1;
    if (!rej) begin
      if (p_we[d]) begin
        for (int i = 0; i < n; i++) mem_m[base + longint'(p_addr[d]) + i] = p_wd[d][8*i +: 8];
      end else begin
        val = 32'd0;
        for (int i = 0; i < n; i++) begin
          key = base + longint'(p_addr[d]) + i;
          if (mem_m.exists(key)) val = val | ({24'd0, mem_m[key]} << (8 * i));
          else exp_known[d] = 1'b0;
        end
        if (p_sx[d] && n < 4 && val[8*n-1]) val = val | ~((32'd1 << (8 * n)) - 32'd1);
        exp_rd[d] = val;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      since[0] = -1;
      since[1] = -1;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (since[d] < 0 || since[d] > wc(d)) begin
          if (req_s[d]) begin
            since[d]  = 0;
            p_we[d]   = we_s[d];
            p_addr[d] = addr_s[d];
            p_size[d] = size_s[d];
            p_sx[d]   = sx_s[d];
            p_wd[d]   = wd_s[d];
          end else begin
            since[d] = -1;
          end
        end else begin
          since[d]++;
        end
        if (since[d] == wc(d)) resolve(d);
      end
    end
  end

  // One compare process: every cycle, every output of both responders.
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      logic eb, ea;
      eb = (since[d] >= 0) && (since[d] <= wc(d));
      ea = (since[d] == wc(d));
      check($sformatf("dut%0d busy", d), {31'd0, busy_s[d]}, {31'd0, eb});
      check($sformatf("dut%0d ack", d), {31'd0, ack_s[d]}, {31'd0, ea});
      if (ea) begin
        check($sformatf("dut%0d err", d), {31'd0, err_s[d]}, {31'd0, exp_err[d]});
        if (exp_known[d]) check($sformatf("dut%0d rdata", d), rdata_s[d], exp_rd[d]);
      end else begin
        check($sformatf("dut%0d idle err", d), {31'd0, err_s[d]}, 32'd0);
        check($sformatf("dut%0d idle rdata", d), rdata_s[d], 32'd0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic set_req(input int d, input logic r, input logic we, input logic [31:0] a,
                         input logic [1:0] sz, input logic sx, input logic [31:0] wd);
    if (d == 0) begin
      bus0.req = r; bus0.we = we; bus0.addr = a; bus0.size = sz; bus0.sign_ext = sx; bus0.wdata = wd;
    end else begin
      bus1.req = r; bus1.we = we; bus1.addr = a; bus1.size = sz; bus1.sign_ext = sx; bus1.wdata = wd;
    end
  endtask

  task automatic xact(input int d, input logic we, input logic [31:0] a, input logic [1:0] sz,
                      input logic sx, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat, output int busy_n);
    @(negedge clk);
    set_req(d, 1'b1, we, a, sz, sx, wd);
    lat = 0; busy_n = 0; rd = 32'd0; er = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      lat++;
      if (busy_s[d]) busy_n++;
      if (ack_s[d]) begin
        rd = rdata_s[d];
        er = err_s[d];
        break;
      end
    end
    check($sformatf("dut%0d ack within budget", d), {31'd0, ack_s[d]}, 32'd1);
    set_req(d, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0);
  endtask

  task automatic rand_txn(input int d);
    logic [31:0] a, wd, rd;
    logic [1:0]  sz;
    logic        we, sx, er;
    int          lat, bn;
    case ($urandom_range(0, 9))
      0:       a = $urandom;
      1:       a = 32'h1000 + $urandom_range(0, 255);
      default: a = $urandom_range(0, 255);
    endcase
    sz = 2'($urandom_range(0, 3));
    we = 1'($urandom_range(0, 1));
    sx = 1'($urandom_range(0, 1));
    wd = $urandom;
    xact(d, we, a, sz, sx, wd, rd, er, lat, bn);
    check($sformatf("dut%0d latency", d), lat, wc(d) + 1);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, bn;
    int          first_ack, second_ack, acks;

    set_req(0, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0);
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d reset busy", d), {31'd0, busy_s[d]}, 32'd0);
      check($sformatf("dut%0d reset ack", d), {31'd0, ack_s[d]}, 32'd0);
      check($sformatf("dut%0d reset err", d), {31'd0, err_s[d]}, 32'd0);
      check($sformatf("dut%0d reset rdata", d), rdata_s[d], 32'd0);
    end
    reset_n = 1'b1;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++)
        xact(d, 1'b1, 32'(i * 4), 2'b10, 1'b0, $urandom, rd, er, lat, bn);

    // Word store/load, one wait state.
    xact(0, 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, rd, er, lat, bn);
    check("word store err", {31'd0, er}, 32'd0);
    xact(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'd0, rd, er, lat, bn);
    check("word load data", rd, 32'hDEADBEEF);
    check("word load latency", lat, 2);

    // Byte lanes.
    xact(0, 1'b1, 32'h13, 2'b00, 1'b0, 32'h00000080, rd, er, lat, bn);
    xact(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'd0, rd, er, lat, bn);
    check("byte store merge", rd, 32'h80ADBEEF);
    xact(0, 1'b0, 32'h13, 2'b00, 1'b1, 32'd0, rd, er, lat, bn);
    check("byte load sext", rd, 32'hFFFFFF80);
    xact(0, 1'b0, 32'h13, 2'b00, 1'b0, 32'd0, rd, er, lat, bn);
    check("byte load zext", rd, 32'h00000080);
    xact(0, 1'b0, 32'h10, 2'b01, 1'b1, 32'd0, rd, er, lat, bn);
    check("half load sext", rd, 32'hFFFFBEEF);

    // Misaligned store is rejected and leaves memory alone.
    xact(0, 1'b1, 32'h12, 2'b10, 1'b0, 32'h12345678, rd, er, lat, bn);
    check("misaligned err", {31'd0, er}, 32'd1);
    check("misaligned rdata", rd, 32'd0);
    xact(0, 1'b0, 32'h10, 2'b10, 1'b0, 32'd0, rd, er, lat, bn);
    check("after misaligned", rd, 32'h80ADBEEF);

    // Range boundary.
    xact(0, 1'b0, 32'h1000, 2'b10, 1'b0, 32'd0, rd, er, lat, bn);
    check("out of range err", {31'd0, er}, 32'd1);
    xact(0, 1'b1, 32'hFFC, 2'b10, 1'b0, 32'hCAFEF00D, rd, er, lat, bn);
    xact(0, 1'b0, 32'hFFC, 2'b10, 1'b0, 32'd0, rd, er, lat, bn);
    check("last word err", {31'd0, er}, 32'd0);
    check("last word data", rd, 32'hCAFEF00D);

    // Three wait states: busy span, latency, and re-acceptance with req held.
    xact(1, 1'b1, 32'h40, 2'b10, 1'b0, 32'hA5A55A5A, rd, er, lat, bn);
    xact(1, 1'b0, 32'h40, 2'b10, 1'b0, 32'd0, rd, er, lat, bn);
    check("wait3 data", rd, 32'hA5A55A5A);
    check("wait3 busy cycles", bn, 4);
    check("wait3 latency", lat, 4);
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, 32'h40, 2'b10, 1'b0, 32'd0);
    first_ack = -1; second_ack = -1; acks = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (ack_s[1]) begin
        acks++;
        if (first_ack < 0) first_ack = c;
        else second_ack = c;
      end
    end
    set_req(1, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0);
    check("held req ack count", acks, 2);
    check("held req first ack", first_ack, 4);
    check("held req second ack", second_ack, 9);
    repeat (6) @(negedge clk);

    // Reset in the middle of a pending store.
    xact(0, 1'b1, 32'h20, 2'b10, 1'b0, 32'h11223344, rd, er, lat, bn);
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 32'h20, 2'b00, 1'b0, 32'h00000055);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("reset busy drop", {31'd0, busy_s[0]}, 32'd0);
    check("reset ack drop", {31'd0, ack_s[0]}, 32'd0);
    check("reset err drop", {31'd0, err_s[0]}, 32'd0);
    check("reset rdata drop", rdata_s[0], 32'd0);
    set_req(0, 1'b0, 1'b0, 32'd0, 2'b00, 1'b0, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    xact(0, 1'b0, 32'h20, 2'b10, 1'b0, 32'd0, rd, er, lat, bn);
    check("dropped store", rd, 32'h11223344);
    check("latency after reset", lat, 2);

    for (int i = 0; i < 250; i++) rand_txn(0);
    for (int i = 0; i < 80; i++)  rand_txn(1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
